nota_media: RTL and testbench

NOTA_MEDIA -- requirements
Module: nota_media

---
 rtl/nota_pkg.sv | 8 +
 rtl/nota_media_if.sv | 20 ++
 rtl/seq_divider.sv | 61 ++++++
 rtl/nota_media.sv | 121 ++++++++++++
 tb/tb_nota_media.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/nota_pkg.sv
// nota_pkg: shared constants and FSM state type for the grade-average block
package nota_pkg;
    localparam int NOTA_MAX = 10;
    localparam int MAX_NOTAS = 8;
    localparam int SUM_W = 7;
    localparam logic [3:0] NOTA_NONE = 4'hF;
    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;
endpackage

// File: rtl/nota_media_if.sv
// nota_media_if: grade entry strobes and average/status results
interface nota_media_if;
    logic [3:0] nota_in;
    logic       nota_valid;
    logic       calc;
    logic       clear;
    logic [3:0] notas;
    logic       notas_valid;
    logic       busy;
    logic [3:0] count;
    logic       error;
    modport master (
        output nota_in, nota_valid, calc, clear,
        input  notas, notas_valid, busy, count, error
    );
    modport slave (
        input  nota_in, nota_valid, calc, clear,
        output notas, notas_valid, busy, count, error
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle, done pulses after the last bit
module seq_divider import nota_pkg::*; (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [SUM_W-1:0] dividend_i,
    input  logic [3:0]       divisor_i,
    output logic [SUM_W-1:0] quotient_o,
    output logic             done_o
);
    logic [SUM_W-1:0] q_q, q_d;
    logic [3:0]       d_q, d_d;
    logic [3:0]       rem_q, rem_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [4:0]       trial;
    logic             ge;

    assign trial = {rem_q, q_q[SUM_W-1]};
    assign ge = trial >= {1'b0, d_q};

    // start reloads unconditionally so an abandoned run never leaks a done pulse
    always_comb begin
        q_d = q_q;
        d_d = d_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        done_d = 1'b0;
        if (start_i) begin
            q_d = dividend_i;
            d_d = divisor_i;
            rem_d = '0;
            cnt_d = 3'(SUM_W);
        end else if (cnt_q != 3'd0) begin
            q_d = {q_q[SUM_W-2:0], ge};
            rem_d = ge ? 4'(trial - {1'b0, d_q}) : trial[3:0];
            cnt_d = cnt_q - 3'd1;
            done_d = cnt_q == 3'd1;
        end
    end

    // divider state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
            d_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            q_q <= q_d;
            d_q <= d_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient_o = q_q;
    assign done_o = done_q;
endmodule

// File: rtl/nota_media.sv
// nota_media: accumulates up to MAX_NOTAS grades and reports their truncated average
module nota_media #(
    parameter int MAX_NOTAS = nota_pkg::MAX_NOTAS,
    parameter int NOTA_MAX = nota_pkg::NOTA_MAX
) (
    input logic        clk_2,
    input logic        rst_n,
    nota_media_if.slave bus
);
    import nota_pkg::*;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [3:0]       count_q, count_d;
    logic [3:0]       notas_q, notas_d;
    logic             notas_valid_q, notas_valid_d;
    logic             error_q, error_d;
    logic             div_start, div_done;
    logic [SUM_W-1:0] quot;
    logic             legal, room;

    assign legal = bus.nota_in <= 4'(NOTA_MAX);
    assign room = count_q < 4'(MAX_NOTAS);

    // next state: clear wins, then per-state grade/calc handling; divider sees post-accept sum/count
    always_comb begin
        state_d = state_q;
        sum_d = sum_q;
        count_d = count_q;
        notas_d = notas_q;
        notas_valid_d = notas_valid_q;
        error_d = 1'b0;
        div_start = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            sum_d = '0;
            count_d = '0;
            notas_d = '0;
            notas_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (bus.nota_valid) begin
                        if (legal && room) begin
                            sum_d = sum_q + SUM_W'(bus.nota_in);
                            count_d = count_q + 4'd1;
                            state_d = ACCUM;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                    if (bus.calc) begin
                        if (count_d == 4'd0) begin
                            state_d = DONE;
                            notas_d = NOTA_NONE;
                            notas_valid_d = 1'b1;
                            error_d = 1'b1;
                        end else begin
                            state_d = DIVIDE;
                            div_start = 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        state_d = DONE;
                        notas_d = quot > SUM_W'(15) ? NOTA_NONE : quot[3:0];
                        notas_valid_d = 1'b1;
                    end
                end
                default: begin
                    if (bus.nota_valid) begin
                        if (legal) begin
                            sum_d = SUM_W'(bus.nota_in);
                            count_d = 4'd1;
                            state_d = ACCUM;
                            notas_valid_d = 1'b0;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // state and registered outputs
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q <= '0;
            count_q <= '0;
            notas_q <= '0;
            notas_valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q <= sum_d;
            count_q <= count_d;
            notas_q <= notas_d;
            notas_valid_q <= notas_valid_d;
            error_q <= error_d;
        end
    end

    seq_divider u_div (
        .clk_i      (clk_2),
        .rst_ni     (rst_n),
        .start_i    (div_start),
        .dividend_i (sum_d),
        .divisor_i  (count_d),
        .quotient_o (quot),
        .done_o     (div_done)
    );

    assign bus.notas = notas_q;
    assign bus.notas_valid = notas_valid_q;
    assign bus.error = error_q;
    assign bus.busy = state_q == DIVIDE;
    assign bus.count = count_q;
endmodule

// File: tb/tb_nota_media.sv
// tb_nota_media: directed scenarios plus random traffic against a grade-list reference model
module tb_nota_media;
    logic clk_2 = 1'b0;
    logic rst_n = 1'b0;
    nota_media_if bus();

    nota_media dut (
        .clk_2 (clk_2),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_2 = ~clk_2;

    int    n_vec = 0;
    int    n_bad = 0;
    string phase = "reset";
    int    grades[$];
    int    res, pend, wait_c;
    bit    have, x_err;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d expected %0d at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        grades.delete();
        res = 0;
        pend = 0;
        wait_c = 0;
        have = 0;
        x_err = 0;
    endtask

    task automatic model_edge(input bit v, input int ni, input bit c, input bit clr);
        x_err = 0;
        if (clr) begin
            grades.delete();
            res = 0;
            have = 0;
            wait_c = 0;
        end else if (wait_c > 0) begin
            wait_c--;
            if (wait_c == 0) begin
                have = 1;
                res = pend;
            end
        end else if (have) begin
            if (v) begin
                if (ni <= 10) begin
                    grades.delete();
                    grades.push_back(ni);
                    have = 0;
                end else begin
                    x_err = 1;
                end
            end
        end else begin
            if (v) begin
                if (ni <= 10 && grades.size() < 8) grades.push_back(ni);
                else x_err = 1;
            end
            if (c) begin
                if (grades.size() == 0) begin
                    have = 1;
                    res = 15;
                    x_err = 1;
                end else begin
                    wait_c = 8;
                    pend = grades.sum() / grades.size();
                end
            end
        end
    endtask

    task automatic check_all();
        chk("count", int'(bus.count), grades.size());
        chk("notas_valid", int'(bus.notas_valid), int'(have));
        chk("notas", int'(bus.notas), res);
        chk("busy", int'(bus.busy), int'(wait_c > 0));
        chk("error", int'(bus.error), int'(x_err));
    endtask

    task automatic cyc(input bit v, input int ni, input bit c, input bit clr);
        bus.nota_valid = v;
        bus.nota_in = 4'(ni);
        bus.calc = c;
        bus.clear = clr;
        @(posedge clk_2);
        model_edge(v, ni, c, clr);
        #1;
        check_all();
        bus.nota_valid = 1'b0;
        bus.calc = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.nota_in = '0;
        bus.nota_valid = 1'b0;
        bus.calc = 1'b0;
        bus.clear = 1'b0;
        model_reset();
        #8;
        check_all();
        #4;
        rst_n = 1'b1;

        phase = "avg789";
        cyc(1, 7, 0, 0);
        cyc(1, 8, 0, 0);
        cyc(1, 9, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (7) cyc(0, 0, 0, 0);
        chk("early_valid", int'(bus.notas_valid), 0);
        cyc(0, 0, 0, 0);
        chk("valid8", int'(bus.notas_valid), 1);
        chk("notas8", int'(bus.notas), 8);
        chk("count3", int'(bus.count), 3);

        phase = "calc_with_grade";
        cyc(0, 0, 0, 1);
        cyc(1, 10, 0, 0);
        cyc(1, 9, 1, 0);
        repeat (3) cyc(1, 4, 1, 0);
        repeat (5) cyc(0, 0, 0, 0);
        chk("notas9", int'(bus.notas), 9);

        phase = "full_set";
        cyc(0, 0, 0, 1);
        repeat (8) cyc(1, 10, 0, 0);
        cyc(1, 10, 0, 0);
        chk("overflow_err", int'(bus.error), 1);
        chk("count8", int'(bus.count), 8);
        cyc(0, 0, 1, 0);
        repeat (8) cyc(0, 0, 0, 0);
        chk("notas10", int'(bus.notas), 10);
        cyc(0, 0, 1, 0);
        cyc(1, 13, 0, 0);
        cyc(1, 2, 0, 0);

        phase = "illegal_empty";
        cyc(0, 0, 0, 1);
        cyc(1, 12, 0, 0);
        chk("illegal_err", int'(bus.error), 1);
        chk("count0", int'(bus.count), 0);
        cyc(0, 0, 1, 0);
        chk("none_valid", int'(bus.notas_valid), 1);
        chk("none_notas", int'(bus.notas), 15);

        phase = "reset_mid_div";
        cyc(0, 0, 0, 1);
        cyc(1, 3, 0, 0);
        cyc(1, 4, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #4;
        rst_n = 1'b1;
        cyc(1, 5, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (8) cyc(0, 0, 0, 0);
        chk("notas5", int'(bus.notas), 5);

        phase = "clear_vs_grade";
        cyc(1, 3, 0, 0);
        cyc(1, 4, 0, 1);
        chk("clr_count", int'(bus.count), 0);
        chk("clr_valid", int'(bus.notas_valid), 0);

        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            int ni;
            ni = ($urandom_range(0, 3) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10));
            cyc($urandom_range(0, 1) == 1, ni, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
